// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage feeding the decode stage. Owns the
//             program counter and issues sequential word fetches over a
//             valid/ready request channel whose responses return in order.
//             A circular buffer of DEPTH entries tracks both in-flight
//             requests and returned instructions. Redirects flush the buffer
//             and discard responses that are still on their way back.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RST_PC        first PC fetched after reset (word aligned)
//    DEPTH         buffer slots shared by in-flight and returned entries
//                  (power of two, >= 2)
//  Ports
//    clk, rst      clock; asynchronous active-high reset
//    imem_req_*    fetch request channel (vld/rdy/addr)
//    imem_rsp_*    in-order response channel, no back-pressure (vld/dat)
//    redirect_*    taken branch/jump: restart fetch at redirect_pc
//    id_rdy        decode consumes the presented instruction this cycle
//    if_vld/inst/pc instruction presented to decode (NOP / 0 when invalid)
//  Build option
//    FETCH_BYPASS_EN  when defined, a response filling the head entry is
//                     presented to decode in the same cycle it arrives.
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RST_PC = 32'h0000_0000,
  parameter int          DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_vld,
  input  logic        imem_req_rdy,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_dat,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  input  logic        id_rdy,
  output logic        if_vld,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0]   NOP_INST  = 32'h0000_0013;
  localparam logic [PW:0]   DEPTH_CNT = DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_unit: DEPTH must be a power of two and at least 2");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]      pc_q, pc_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      ent_pc_q   [DEPTH];
  logic [31:0]      ent_inst_q [DEPTH];

  // --------------------------------------------------------------------------
  // Derived control
  // --------------------------------------------------------------------------
  logic [AW-1:0] wr_idx, fill_idx, rd_idx;
  logic [PW-1:0] occupancy, pending;
  logic          drop_zero;
  logic          has_budget;
  logic          req_fire;
  logic          rsp_fill_ok;
  logic          rsp_take;
  logic          rsp_drop;
  logic          bypass;
  logic          pop;
  logic [1:0]    redirect_pc_unused;

  assign wr_idx    = wr_ptr_q[AW-1:0];
  assign fill_idx  = fill_ptr_q[AW-1:0];
  assign rd_idx    = rd_ptr_q[AW-1:0];
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign pending   = wr_ptr_q - fill_ptr_q;
  assign drop_zero = (drop_cnt_q == '0);

  // Responses still owed to a flushed stream occupy memory-side capacity,
  // so they count against the slot budget alongside live entries.
  assign has_budget   = ({1'b0, occupancy} + {1'b0, drop_cnt_q}) < DEPTH_CNT;
  assign imem_req_vld = ~rst & ~redirect_vld & has_budget;
  assign imem_req_addr = pc_q;
  assign req_fire     = imem_req_vld & imem_req_rdy;

  // A response with no outstanding unfilled entry is ignored.
  assign rsp_fill_ok = imem_rsp_vld & drop_zero & (pending != '0);
  assign rsp_take    = rsp_fill_ok & ~redirect_vld;
  assign rsp_drop    = imem_rsp_vld & ~drop_zero;

`ifdef FETCH_BYPASS_EN
  // rsp_take already excludes redirect and drop cycles; the head is the
  // next entry to fill only when fill_ptr has not yet passed rd_ptr.
  assign bypass = rsp_take & (fill_ptr_q == rd_ptr_q);
`else
  assign bypass = 1'b0;
`endif

  assign redirect_pc_unused = redirect_pc[1:0];

  // --------------------------------------------------------------------------
  // Decode-side outputs
  // --------------------------------------------------------------------------
  always_comb begin
    if_vld  = 1'b0;
    if_inst = NOP_INST;
    if_pc   = 32'h0000_0000;
    if (!redirect_vld) begin
      if (filled_q[rd_idx]) begin
        if_vld  = 1'b1;
        if_inst = ent_inst_q[rd_idx];
        if_pc   = ent_pc_q[rd_idx];
      end else if (bypass) begin
        if_vld  = 1'b1;
        if_inst = imem_rsp_dat;
        if_pc   = ent_pc_q[rd_idx];
      end
    end
  end

  assign pop = if_vld & id_rdy;

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    filled_d   = filled_q;

    if (redirect_vld) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      fill_ptr_d = wr_ptr_q;
      rd_ptr_d   = wr_ptr_q;
      filled_d   = '0;
      // Every response not yet written, plus those already being dropped,
      // must be discarded; one arriving this cycle is consumed right now.
      drop_cnt_d = drop_cnt_q + pending - PW'(rsp_fill_ok) - PW'(rsp_drop);
    end else begin
      if (req_fire) begin
        pc_d             = pc_q + 32'd4;
        wr_ptr_d         = wr_ptr_q + PTR_ONE;
        filled_d[wr_idx] = 1'b0;
      end
      if (rsp_take) begin
        fill_ptr_d         = fill_ptr_q + PTR_ONE;
        filled_d[fill_idx] = 1'b1;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - PTR_ONE;
      end
      // Ordered after the fill so a bypassed entry is cleared as it pops.
      if (pop) begin
        rd_ptr_d         = rd_ptr_q + PTR_ONE;
        filled_d[rd_idx] = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RST_PC;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      filled_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      filled_q   <= filled_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind filled_q.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      ent_pc_q[wr_idx] <= pc_q;
    end
    if (rsp_take) begin
      ent_inst_q[fill_idx] <= imem_rsp_dat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit (RST_PC=0x100,
//             DEPTH=4) with a fixed-latency in-order memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk          = 1'b0;
  logic        rst          = 1'b1;
  logic        imem_req_rdy = 1'b0;
  logic        imem_rsp_vld = 1'b0;
  logic [31:0] imem_rsp_dat = '0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc  = '0;
  logic        id_rdy       = 1'b0;
  logic        imem_req_vld;
  logic [31:0] imem_req_addr;
  logic        if_vld;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(
    .RST_PC (RST_PC),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_vld  (imem_req_vld),
    .imem_req_rdy  (imem_req_rdy),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_vld  (imem_rsp_vld),
    .imem_rsp_dat  (imem_rsp_dat),
    .redirect_vld  (redirect_vld),
    .redirect_pc   (redirect_pc),
    .id_rdy        (id_rdy),
    .if_vld        (if_vld),
    .if_inst       (if_inst),
    .if_pc         (if_pc)
  );

  always #5 clk = ~clk;

  // Instruction word stored at a given address in the memory model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // --------------------------------------------------------------------------
  // Memory model: fixed latency mem_lat, responses in acceptance order.
  // --------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;

  req_t mq[$];
  req_t mreq;
  int   cyc     = 0;
  int   mem_lat = 1;

  always begin
    @(negedge clk);
    if (rst) begin
      mq.delete();
    end else if (imem_req_vld && imem_req_rdy) begin
      mreq.due  = cyc + mem_lat;
      mreq.addr = imem_req_addr;
      mq.push_back(mreq);
    end
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (!rst && mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_vld = 1'b1;
      imem_rsp_dat = mem_word(mq[0].addr);
      mq.pop_front();
    end else begin
      imem_rsp_vld = 1'b0;
      imem_rsp_dat = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    id_rdy       = 1'b0;
    imem_req_rdy = 1'b0;
    repeat (2) step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    step();
    @(negedge clk);
    n_cmp++; if (imem_req_vld !== 1'b0) begin n_fail++; $display("FAIL rst_req_vld: got %b want 0", imem_req_vld); end
    n_cmp++; if (if_vld !== 1'b0) begin n_fail++; $display("FAIL rst_if_vld: got %b want 0", if_vld); end
    n_cmp++; if (if_inst !== NOP) begin n_fail++; $display("FAIL rst_if_inst: got %h want %h", if_inst, NOP); end
    n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
  endtask

  // Sequential stream, k=1, decode always ready.
  task automatic test_stream();
    logic [31:0] epc;
    do_reset();
    mem_lat = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; imem_req_rdy = 1'b1; id_rdy = 1'b1; end
      @(negedge clk);
      n_cmp++; if (imem_req_vld !== 1'b1) begin n_fail++; $display("FAIL stream_req_vld c%0d: got %b want 1", c, imem_req_vld); end
      n_cmp++; if (imem_req_addr !== RST_PC + 32'(4 * c)) begin n_fail++; $display("FAIL stream_addr c%0d: got %h want %h", c, imem_req_addr, RST_PC + 32'(4 * c)); end
      n_cmp++; if (if_vld !== (c >= 2)) begin n_fail++; $display("FAIL stream_if_vld c%0d: got %b want %b", c, if_vld, (c >= 2)); end
      if (c >= 2) begin
        epc = RST_PC + 32'(4 * (c - 2));
        n_cmp++; if (if_pc !== epc) begin n_fail++; $display("FAIL stream_if_pc c%0d: got %h want %h", c, if_pc, epc); end
        n_cmp++; if (if_inst !== mem_word(epc)) begin n_fail++; $display("FAIL stream_if_inst c%0d: got %h want %h", c, if_inst, mem_word(epc)); end
      end else begin
        n_cmp++; if (if_inst !== NOP) begin n_fail++; $display("FAIL stream_nop c%0d: got %h want %h", c, if_inst, NOP); end
      end
    end
  endtask

  // Decode stalled: buffer fills to DEPTH, then drains in order.
  task automatic test_backpressure();
    int          n_acc;
    logic [31:0] epc;
    do_reset();
    mem_lat = 1;
    n_acc   = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; imem_req_rdy = 1'b1; id_rdy = 1'b0; end
      @(negedge clk);
      if (imem_req_vld && imem_req_rdy) n_acc++;
      n_cmp++; if (imem_req_vld !== (c < DEPTH)) begin n_fail++; $display("FAIL bp_req_vld c%0d: got %b want %b", c, imem_req_vld, (c < DEPTH)); end
      n_cmp++; if (if_vld !== (c >= 2)) begin n_fail++; $display("FAIL bp_if_vld c%0d: got %b want %b", c, if_vld, (c >= 2)); end
      if (c >= 2) begin
        n_cmp++; if (if_pc !== RST_PC) begin n_fail++; $display("FAIL bp_hold_pc c%0d: got %h want %h", c, if_pc, RST_PC); end
      end
    end
    n_cmp++; if (n_acc != DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", n_acc, DEPTH); end
    for (int c = 8; c < 13; c++) begin
      step();
      if (c == 8) id_rdy = 1'b1;
      @(negedge clk);
      epc = RST_PC + 32'(4 * (c - 8));
      n_cmp++; if (if_vld !== 1'b1) begin n_fail++; $display("FAIL bp_drain_vld c%0d: got %b want 1", c, if_vld); end
      n_cmp++; if (if_pc !== epc) begin n_fail++; $display("FAIL bp_drain_pc c%0d: got %h want %h", c, if_pc, epc); end
      n_cmp++; if (if_inst !== mem_word(epc)) begin n_fail++; $display("FAIL bp_drain_inst c%0d: got %h want %h", c, if_inst, mem_word(epc)); end
      n_cmp++; if (imem_req_vld !== (c != 8)) begin n_fail++; $display("FAIL bp_resume_vld c%0d: got %b want %b", c, imem_req_vld, (c != 8)); end
      if (c == 9) begin
        n_cmp++; if (imem_req_addr !== RST_PC + 32'h10) begin n_fail++; $display("FAIL bp_resume_addr: got %h want %h", imem_req_addr, RST_PC + 32'h10); end
      end
    end
  endtask

  // k=3, two requests pending, redirect to an unaligned target.
  task automatic test_redirect_stale();
    do_reset();
    mem_lat = 3;
    for (int c = 0; c < 9; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; imem_req_rdy = 1'b1; id_rdy = 1'b1; end
      if (c == 2) begin redirect_vld = 1'b1; redirect_pc = 32'h0000_2003; end
      if (c == 3) redirect_vld = 1'b0;
      @(negedge clk);
      if (c < 2) begin
        n_cmp++; if (imem_req_addr !== RST_PC + 32'(4 * c)) begin n_fail++; $display("FAIL rds_pre_addr c%0d: got %h want %h", c, imem_req_addr, RST_PC + 32'(4 * c)); end
      end
      if (c == 2) begin
        n_cmp++; if (imem_req_vld !== 1'b0) begin n_fail++; $display("FAIL rds_redir_req: got %b want 0", imem_req_vld); end
      end
      if (c >= 3 && c <= 5) begin
        n_cmp++; if (imem_req_vld !== 1'b1) begin n_fail++; $display("FAIL rds_req_vld c%0d: got %b want 1", c, imem_req_vld); end
        n_cmp++; if (imem_req_addr !== 32'h2000 + 32'(4 * (c - 3))) begin n_fail++; $display("FAIL rds_addr c%0d: got %h want %h", c, imem_req_addr, 32'h2000 + 32'(4 * (c - 3))); end
      end
      if (c < 7) begin
        n_cmp++; if (if_vld !== 1'b0) begin n_fail++; $display("FAIL rds_stale_vld c%0d: got %b want 0 (pc %h)", c, if_vld, if_pc); end
      end else begin
        n_cmp++; if (if_vld !== 1'b1) begin n_fail++; $display("FAIL rds_tgt_vld c%0d: got %b want 1", c, if_vld); end
        n_cmp++; if (if_pc !== 32'h2000 + 32'(4 * (c - 7))) begin n_fail++; $display("FAIL rds_tgt_pc c%0d: got %h want %h", c, if_pc, 32'h2000 + 32'(4 * (c - 7))); end
        n_cmp++; if (if_inst !== mem_word(32'h2000 + 32'(4 * (c - 7)))) begin n_fail++; $display("FAIL rds_tgt_inst c%0d: got %h want %h", c, if_inst, mem_word(32'h2000 + 32'(4 * (c - 7)))); end
      end
    end
  endtask

  // k=2, redirect lands on the same cycle as a response and a filled head.
  task automatic test_redirect_rsp();
    do_reset();
    mem_lat = 2;
    for (int c = 0; c < 9; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; imem_req_rdy = 1'b1; id_rdy = 1'b1; end
      if (c == 3) begin redirect_vld = 1'b1; redirect_pc = 32'h0000_3000; end
      if (c == 4) redirect_vld = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        n_cmp++; if (imem_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL rdr_coincident_rsp: got %b want 1", imem_rsp_vld); end
        n_cmp++; if (imem_req_vld !== 1'b0) begin n_fail++; $display("FAIL rdr_redir_req: got %b want 0", imem_req_vld); end
        n_cmp++; if (if_inst !== NOP) begin n_fail++; $display("FAIL rdr_redir_inst: got %h want %h", if_inst, NOP); end
      end
      if (c == 4 || c == 5) begin
        n_cmp++; if (imem_req_addr !== 32'h3000 + 32'(4 * (c - 4))) begin n_fail++; $display("FAIL rdr_addr c%0d: got %h want %h", c, imem_req_addr, 32'h3000 + 32'(4 * (c - 4))); end
      end
      if (c >= 3 && c < 7) begin
        n_cmp++; if (if_vld !== 1'b0) begin n_fail++; $display("FAIL rdr_stale_vld c%0d: got %b want 0 (pc %h)", c, if_vld, if_pc); end
      end
      if (c >= 7) begin
        n_cmp++; if (if_vld !== 1'b1) begin n_fail++; $display("FAIL rdr_tgt_vld c%0d: got %b want 1", c, if_vld); end
        n_cmp++; if (if_pc !== 32'h3000 + 32'(4 * (c - 7))) begin n_fail++; $display("FAIL rdr_tgt_pc c%0d: got %h want %h", c, if_pc, 32'h3000 + 32'(4 * (c - 7))); end
      end
    end
  endtask

  // PC wraps from 0xFFFF_FFFC to 0.
  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    exp_addr[3] = 32'h0000_0004;
    do_reset();
    mem_lat = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin
        rst = 1'b0; imem_req_rdy = 1'b1; id_rdy = 1'b1;
        redirect_vld = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      end
      if (c == 1) redirect_vld = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (imem_req_vld !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_req: got %b want 0", imem_req_vld); end
      end
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (imem_req_addr !== exp_addr[c-1]) begin n_fail++; $display("FAIL wrap_addr c%0d: got %h want %h", c, imem_req_addr, exp_addr[c-1]); end
      end
      if (c >= 3) begin
        n_cmp++; if (if_pc !== exp_addr[c-3]) begin n_fail++; $display("FAIL wrap_if_pc c%0d: got %h want %h", c, if_pc, exp_addr[c-3]); end
        n_cmp++; if (if_inst !== mem_word(exp_addr[c-3])) begin n_fail++; $display("FAIL wrap_if_inst c%0d: got %h want %h", c, if_inst, mem_word(exp_addr[c-3])); end
      end
    end
  endtask

  // Asynchronous reset with three instructions buffered.
  task automatic test_reset_mid();
    do_reset();
    mem_lat = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; imem_req_rdy = 1'b1; id_rdy = 1'b0; end
      if (c == 3) imem_req_rdy = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (if_pc !== RST_PC || if_vld !== 1'b1) begin n_fail++; $display("FAIL mid_pre_head: got vld %b pc %h want 1 %h", if_vld, if_pc, RST_PC); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (if_vld !== 1'b0) begin n_fail++; $display("FAIL mid_if_vld: got %b want 0", if_vld); end
    n_cmp++; if (if_inst !== NOP) begin n_fail++; $display("FAIL mid_if_inst: got %h want %h", if_inst, NOP); end
    n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL mid_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (imem_req_vld !== 1'b0) begin n_fail++; $display("FAIL mid_req_vld: got %b want 0", imem_req_vld); end
    step();
    rst = 1'b0;
    imem_req_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req_vld !== 1'b1 || imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL mid_restart: got vld %b addr %h want 1 %h", imem_req_vld, imem_req_addr, RST_PC); end
    n_cmp++; if (if_vld !== 1'b0) begin n_fail++; $display("FAIL mid_restart_if_vld: got %b want 0", if_vld); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
